// File: rtl/wb_drv_cfg_loader.sv
// Loads four driver config words over pipelined Wishbone, with optional readback-compare.
// Latency: 2 cycles per transaction with no stall and ack one cycle after accept; o_done one cycle after the last ack.
// Backpressure: i_wb_stall holds the request stable; a missing ack aborts the sequence after TIMEOUT cycles.
// Ports: clk/reset (async active-low); i_start/i_verify request a sequence; i_cfg0..3 hold the values.
//        o_wb_* / i_wb_* form the Wishbone master; o_busy/o_done/o_err/o_err_idx/o_err_code report status.
module wb_drv_cfg_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_verify,
  input  logic [31:0] i_cfg0,
  input  logic [31:0] i_cfg1,
  input  logic [31:0] i_cfg2,
  input  logic [31:0] i_cfg3,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_idx,
  output logic [1:0]  o_err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             rd_q, rd_d;        // 0 = write pass, 1 = readback pass
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             verify_q, verify_d;
  logic [3:0][31:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic [1:0]       err_idx_q, err_idx_d;
  logic [1:0]       err_code_q, err_code_d;

  logic timeout;
  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    cfg_d      = cfg_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cfg_d      = {i_cfg3, i_cfg2, i_cfg1, i_cfg0};
          verify_d   = i_verify;
          err_d      = 1'b0;
          err_idx_d  = 2'd0;
          err_code_d = 2'd0;
          idx_d      = 2'd0;
          rd_d       = 1'b0;
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
          state_d    = S_FIN;
        end else if (!i_wb_stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the same cycle as the timeout wins.
        if (i_wb_ack) begin
          cnt_d = '0;
          if (rd_q && (i_wb_data != cfg_q[idx_q])) begin
            err_d      = 1'b1;
            err_code_d = ERR_MISMATCH;
            err_idx_d  = idx_q;
            state_d    = S_FIN;
          end else if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_REQ;
          end else if (!rd_q && verify_q) begin
            rd_d    = 1'b1;
            idx_d   = 2'd0;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
          state_d    = S_FIN;
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      verify_q   <= 1'b0;
      cfg_q      <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= 2'd0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      verify_q   <= verify_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  // Bus outputs decode straight from state so an async reset releases the bus immediately.
  logic in_req;
  assign in_req     = (state_q == S_REQ);
  assign o_wb_cyc   = in_req || (state_q == S_WAIT);
  assign o_wb_stb   = in_req;
  assign o_wb_we    = in_req && !rd_q;
  assign o_wb_addr  = in_req ? (BASE_ADDR + {30'd0, idx_q}) : 32'd0;
  assign o_wb_data  = (in_req && !rd_q) ? cfg_q[idx_q] : 32'd0;
  assign o_busy     = o_wb_cyc;
  assign o_done     = (state_q == S_FIN);
  assign o_err      = err_q;
  assign o_err_idx  = err_idx_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_wb_drv_cfg_loader.sv
// Scoreboard bench for wb_drv_cfg_loader: expected bus transactions and completions are queued by
// the stimulus, and a negedge monitor pops and compares them whenever the DUT presents stb or o_done.
// A behavioural Wishbone responder supplies acks, stalls, corrupted readback and dropped acks.
module tb_wb_drv_cfg_loader;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_verify;
  logic [31:0] cfg [4];
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;
  logic        o_busy, o_done, o_err;
  logic [1:0]  o_err_idx, o_err_code;

  wb_drv_cfg_loader #(.BASE_ADDR(BASE), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_verify(i_verify),
    .i_cfg0(cfg[0]), .i_cfg1(cfg[1]), .i_cfg2(cfg[2]), .i_cfg3(cfg[3]),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_idx(o_err_idx), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  typedef struct packed {logic [31:0] dly; logic err; logic [1:0] code; logic [1:0] idx;} done_t;
  txn_t  exp_txn [$];
  done_t exp_done[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Responder configuration, written only by the stimulus process.
  int          stall_idx = -1, stall_len = 0, noack_idx = -1, bad_idx = -1;
  logic        spur_ack = 1'b0;
  logic [31:0] bad_val = 32'd0;

  // Written only by the monitor: accepted-transfer record and responder memory.
  int          acc_cnt = 0;
  logic [31:0] acc_addr;
  logic        acc_we;
  logic [31:0] mem [4];

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (o_wb_stb) begin
        if (exp_txn.size() == 0) begin
          flag("unexpected_txn");
        end else begin
          txn_t t;
          t = exp_txn[0];
          if (!i_wb_stall) void'(exp_txn.pop_front());
          check(i_wb_stall ? "hold_we" : "txn_we", 32'(o_wb_we), 32'(t.we));
          check(i_wb_stall ? "hold_addr" : "txn_addr", o_wb_addr, t.addr);
          check(i_wb_stall ? "hold_data" : "txn_data", o_wb_data, t.data);
          check("txn_cyc", 32'(o_wb_cyc), 32'd1);
        end
        if (!i_wb_stall) begin
          acc_addr = o_wb_addr;
          acc_we   = o_wb_we;
          if (o_wb_we) mem[o_wb_addr[1:0]] = o_wb_data;
          acc_cnt++;
        end
      end
      if (o_done) begin
        if (exp_done.size() == 0) begin
          flag("unexpected_done");
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_cycle", 32'(cyc - start_cyc), d.dly);
          check("done_err", 32'(o_err), 32'(d.err));
          check("done_code", 32'(o_err_code), 32'(d.code));
          check("done_idx", 32'(o_err_idx), 32'(d.idx));
          check("done_cyc_low", {30'd0, o_wb_cyc, o_busy}, 32'd0);
        end
      end
    end
  end

  // Wishbone responder: ack one cycle after accept, optional stall/corrupt/drop.
  int seen_cnt = 0;
  int stall_done = 0;
  always @(posedge clk) begin
    #1;
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = 32'd0;
    if (stall_len == 0) stall_done = 0;
    if (!reset) begin
      seen_cnt = acc_cnt;
    end else begin
      if (acc_cnt != seen_cnt) begin
        seen_cnt = acc_cnt;
        if (int'(acc_addr[1:0]) != noack_idx) begin
          i_wb_ack = 1'b1;
          if (!acc_we)
            i_wb_data = (int'(acc_addr[1:0]) == bad_idx) ? bad_val : mem[acc_addr[1:0]];
        end
      end
      if (o_wb_stb && o_wb_we && int'(o_wb_addr[1:0]) == stall_idx && stall_done < stall_len) begin
        i_wb_stall = 1'b1;
        stall_done++;
        if (spur_ack) i_wb_ack = 1'b1;
      end
    end
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_txn.push_back('{1'b1, BASE + 32'(i), cfg[i]});
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) exp_txn.push_back('{1'b0, BASE + 32'(i), 32'd0});
  endtask

  task automatic push_done(input int dly, input logic err, input logic [1:0] code, input logic [1:0] idx);
    exp_done.push_back('{32'(dly), err, code, idx});
  endtask

  task automatic start_seq(input logic v);
    @(posedge clk); #1;
    i_verify  = v;
    i_start   = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 200 && exp_done.size() != 0; k++) @(posedge clk);
    if (exp_done.size() != 0) flag({name, "_no_done"});
    check({name, "_txn_left"}, 32'(exp_txn.size()), 32'd0);
    exp_done.delete();
    exp_txn.delete();
    @(posedge clk);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctl"}, {23'd0, o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err, o_err_idx, o_err_code}, 32'd0);
    check({name, "_addr"}, o_wb_addr, 32'd0);
    check({name, "_data"}, o_wb_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; i_start = 1'b0; i_verify = 1'b0;
    for (int i = 0; i < 4; i++) cfg[i] = 32'd0;
    #2;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_idle("post_reset");

    // Write-only, with a start pulse during the sequence that must be ignored.
    cfg[0] = 32'hFFFF_FFFF; cfg[1] = 32'h0000_0000; cfg[2] = 32'hA5A5_A5A5; cfg[3] = 32'h0000_00FF;
    push_writes(4);
    push_done(9, 1'b0, 2'd0, 2'd0);
    start_seq(1'b0);
    repeat (2) @(posedge clk); #1;
    check("busy_at_restart", 32'(o_busy), 32'd1);
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done("write_only");

    // Stall index 2 for three cycles; spurious acks during the stall must be ignored.
    stall_idx = 2; stall_len = 3; spur_ack = 1'b1;
    push_writes(4);
    push_done(12, 1'b0, 2'd0, 2'd0);
    start_seq(1'b0);
    wait_done("stall");
    stall_idx = -1; stall_len = 0; spur_ack = 1'b0;

    // Verify pass.
    cfg[0] = 32'h1234_5678; cfg[1] = 32'hDEAD_BEEF; cfg[2] = 32'h0000_0000; cfg[3] = 32'h8000_0001;
    push_writes(4);
    push_reads(4);
    push_done(17, 1'b0, 2'd0, 2'd0);
    start_seq(1'b1);
    wait_done("verify_pass");

    // Verify fail at index 1.
    cfg[0] = 32'hFFFF_FFFF; cfg[1] = 32'h0000_0000; cfg[2] = 32'hA5A5_A5A5; cfg[3] = 32'h0000_00FF;
    bad_idx = 1; bad_val = 32'h0000_0001;
    push_writes(4);
    push_reads(2);
    push_done(13, 1'b1, 2'd2, 2'd1);
    start_seq(1'b1);
    wait_done("verify_fail");
    bad_idx = -1;
    check("sticky_err", {29'd0, o_err, o_err_code}, {29'd0, 1'b1, 2'd2});
    check("sticky_idx", 32'(o_err_idx), 32'd1);

    // Timeout: index 3 never acked.
    noack_idx = 3;
    push_writes(4);
    push_done(23, 1'b1, 2'd1, 2'd3);
    start_seq(1'b0);
    wait_done("timeout");
    noack_idx = -1;
    check("timeout_sticky", {29'd0, o_err, o_err_code}, {29'd0, 1'b1, 2'd1});

    // New start clears the error.
    push_writes(4);
    push_done(9, 1'b0, 2'd0, 2'd0);
    start_seq(1'b0);
    check("err_cleared", {27'd0, o_err, o_err_idx, o_err_code}, 32'd0);
    wait_done("after_timeout");

    // Reset during WAIT of index 1.
    push_writes(2);
    start_seq(1'b0);
    repeat (3) @(posedge clk); #1;
    check("in_wait_idx1", {30'd0, o_wb_cyc, o_wb_stb}, 32'd2);
    #2 reset = 1'b0;
    #1 check_idle("async_reset");
    repeat (3) @(posedge clk); #1;
    check_idle("held_reset");
    reset = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("idle_after_reset", {30'd0, o_busy, o_wb_cyc}, 32'd0);
    check("reset_txn_left", 32'(exp_txn.size()), 32'd0);
    exp_txn.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_drv_cfg_loader.md
WB_DRV_CFG_LOADER -- requirements
Module: wb_drv_cfg_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0300_0000, the word address of driver config register 0.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles allowed per transaction from first stb to ack.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  single-cycle pulse that requests a load sequence.
REQ-007 i_verify  in  1  sampled with i_start; 1 adds a readback-compare pass.
REQ-008 i_cfg0..i_cfg3  in  32 each  values for registers BASE_ADDR+0..+3: sync delays, p delays, n delays, current.
REQ-009 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-010 o_wb_addr, o_wb_data  out  32 each  Wishbone address and write data.
REQ-011 i_wb_ack, i_wb_stall  in  1 each  Wishbone responder acknowledge and stall.
REQ-012 i_wb_data  in  32  Wishbone read data, valid with i_wb_ack.
REQ-013 o_busy  out  1  high from the cycle after an accepted i_start until o_done.
REQ-014 o_done  out  1  one-cycle pulse at the end of every sequence, pass or fail.
REQ-015 o_err  out  1  sticky failure flag, cleared on the next accepted i_start.
REQ-016 o_err_idx  out  2  register index of the first failure.
REQ-017 o_err_code  out  2  failure cause: 0 none, 1 timeout, 2 readback mismatch.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, FIN; a 2-bit index and a write/read phase bit qualify REQ and WAIT.
REQ-019 In IDLE, i_start=1 SHALL be accepted; the block then snapshots i_cfg0..3 and i_verify, clears o_err, o_err_idx and o_err_code, sets index=0 and phase=write, and enters REQ.
REQ-020 i_start SHALL be ignored outside IDLE.
REQ-021 In REQ: o_wb_cyc=1, o_wb_stb=1, o_wb_addr=BASE_ADDR+index, o_wb_we=1 for write (0 for read), o_wb_data=snapshot[index] for write (0 for read).
REQ-022 REQ SHALL hold all of those outputs stable while i_wb_stall=1, and SHALL move to WAIT on the first edge with i_wb_stall=0.
REQ-023 In WAIT: o_wb_stb=0 and o_wb_cyc=1.
REQ-024 i_wb_ack SHALL be honoured only in WAIT; an ack in any other state SHALL be ignored.
REQ-025 On ack in WAIT during the write phase, index<3 SHALL give index+1 and REQ on the next cycle.
REQ-026 On ack in WAIT during the write phase with index=3: verify=1 SHALL give phase=read, index=0, REQ; verify=0 SHALL give FIN.
REQ-027 On ack in WAIT during the read phase, i_wb_data SHALL be compared with snapshot[index].
REQ-028 A read-phase mismatch SHALL set o_err=1, o_err_code=2, o_err_idx=index, and go to FIN; a match SHALL advance as in REQ-025, going to FIN after index 3.
REQ-029 o_wb_cyc SHALL stay high from the first REQ through the last WAIT; cycles between transactions SHALL NOT drop it.
REQ-030 A timeout counter SHALL reset to 0 on entry to REQ and increment each cycle in REQ or WAIT.
REQ-031 When the timeout counter reaches TIMEOUT-1 without an ack, the block SHALL set o_err=1, o_err_code=1, o_err_idx=index, and go to FIN.
REQ-032 Ack and timeout in the same cycle SHALL resolve as ack.
REQ-033 FIN SHALL last one cycle: o_wb_cyc=0, o_wb_stb=0, o_done=1, o_busy=0, then IDLE.
REQ-034 Nominal timing with no stall and ack one cycle after accept: i_start at cycle 0, stb in cycles 1,3,5,7, acks in 2,4,6,8, o_done at 9.
REQ-035 The address SHALL be computed as a 32-bit sum that wraps modulo 2^32.

Reset
REQ-036 With reset=0, the block SHALL asynchronously force state IDLE, index 0 and counter 0.
REQ-037 With reset=0, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_busy, o_done, o_err, o_err_idx and o_err_code SHALL all be 0.
REQ-038 Reset asserted mid-sequence SHALL abort it immediately with no o_done pulse; the bus SHALL be released in the same cycle.
REQ-039 After release, the block SHALL wait for a fresh i_start.

Verification
REQ-040 Write-only: cfg0..3=FFFF_FFFF, 0000_0000, A5A5_A5A5, 0000_00FF, verify=0, ack 1 cycle after accept -> writes to 0300_0000..0300_0003 with matching data; o_done at cycle 9; o_err=0.
REQ-041 Stall: i_wb_stall=1 for 3 cycles on index 2 -> addr 0300_0002 and data A5A5_A5A5 held all 3 cycles; sequence completes; o_done 3 cycles later than in REQ-040.
REQ-042 Verify pass: responder returns written values -> 8 transactions (4 we=1, then 4 we=0); o_err=0; o_done after the 8th ack.
REQ-043 Verify fail: readback of index 1 returns 0000_0001 -> o_err=1, o_err_code=2, o_err_idx=1; no read of index 2; cyc low in the o_done cycle.
REQ-044 Timeout: no ack for index 3, TIMEOUT=16 -> o_err_code=1, o_err_idx=3, o_done 16 cycles after index 3 entered REQ; a new i_start clears o_err.
REQ-045 Reset and ignore: reset=0 during WAIT of index 1 -> all outputs 0 at once and no o_done; i_start pulsed while o_busy=1 -> ignored.
